// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler: walks the conv loop nest (tile, oy, ox, ky, kx, cw), issuing
// IFM/weight reads and framing each output pixel with PE_reset / PE_finish.
module conv_tile_scheduler #(
    parameter int ADDR_W = 20,
    parameter int NUM_PE = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        KERNEL_W,
    input  logic [7:0]        IFM_W,
    input  logic [7:0]        IFM_C,
    input  logic [7:0]        OFM_W,
    input  logic [7:0]        OFM_C,
    input  logic [1:0]        stride,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic [NUM_PE-1:0] PE_reset,
    output logic [NUM_PE-1:0] PE_finish,
    output logic [7:0]        ofm_x,
    output logic [7:0]        ofm_y,
    output logic [7:0]        tile_idx
);
    typedef enum logic [2:0] {IDLE, CHECK, CLEAR, ACCUM, DRAIN, FINISH, DONE} state_t;
    state_t state, state_n;
    logic [3:0] k, ky;
    logic [7:0] iw, ic, ow, oc, d_cnt;
    logic [1:0] st;
    logic [5:0] cw;
    logic [15:0] row_len, n_rd, rc;
    logic [ADDR_W-1:0] row_stride, px_step, oy_step, pix_base, oy_base, ifm_row, wgt_base;
    logic bad, last_rd, last_px;
    assign cw = ic[7:2];
    assign bad = (k == 4'd0) || (st == 2'd0) || (ic == 8'd0) || (ic[1:0] != 2'd0) ||
                 (oc == 8'd0) || (oc[3:0] != 4'd0) || (ow == 8'd0) ||
                 (({4'd0, ow} - 12'd1) * {10'd0, st} + {8'd0, k} > {4'd0, iw});
    assign last_rd = (ky == k - 4'd1) && (rc == row_len - 16'd1);
    assign last_px = (ofm_x == ow - 8'd1) && (ofm_y == ow - 8'd1) &&
                     (tile_idx == {4'd0, oc[7:4]} - 8'd1);
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n   = state;
        busy      = state != IDLE;
        done      = state == DONE;
        ifm_rd_en = state == ACCUM;
        wgt_rd_en = state == ACCUM;
        PE_reset  = {NUM_PE{state == CLEAR}};
        PE_finish = {NUM_PE{state == FINISH}};
        case (state)
            IDLE:    state_n = start ? CHECK : IDLE;
            CHECK:   state_n = bad ? DONE : CLEAR;
            CLEAR:   state_n = ACCUM;
            ACCUM:   state_n = last_rd ? DRAIN : ACCUM;
            DRAIN:   state_n = (d_cnt == 8'(RD_LAT - 1)) ? FINISH : DRAIN;
            FINISH:  state_n = stall ? FINISH : (last_px ? DONE : CLEAR);
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            {k, iw, ic, ow, oc, st} <= '0;
            {cfg_err, ofm_x, ofm_y, tile_idx, ky, rc, d_cnt, row_len, n_rd} <= '0;
            {ifm_addr, wgt_addr, row_stride, px_step, oy_step} <= '0;
            {pix_base, oy_base, ifm_row, wgt_base} <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    {k, iw, ic, ow, oc, st} <= {KERNEL_W, IFM_W, IFM_C, OFM_W, OFM_C, stride};
                    {cfg_err, ofm_x, ofm_y, tile_idx} <= '0;
                    {pix_base, oy_base, wgt_base} <= '0;
                end
                CHECK: begin
                    cfg_err    <= bad;
                    row_len    <= 16'(k) * 16'(cw);
                    n_rd       <= 16'(k) * 16'(k) * 16'(cw);
                    row_stride <= ADDR_W'(iw) * ADDR_W'(cw);
                    px_step    <= ADDR_W'(st) * ADDR_W'(cw);
                    oy_step    <= ADDR_W'(st) * ADDR_W'(iw) * ADDR_W'(cw);
                end
                CLEAR: begin
                    ifm_addr <= pix_base;
                    ifm_row  <= pix_base;
                    wgt_addr <= wgt_base;
                    rc       <= '0;
                    ky       <= '0;
                    d_cnt    <= '0;
                end
                ACCUM: begin
                    wgt_addr <= wgt_addr + ADDR_W'(1);
                    // kx and cw are contiguous in memory, so a kernel row is a linear run
                    if (rc == row_len - 16'd1) begin
                        rc       <= '0;
                        ky       <= ky + 4'd1;
                        ifm_row  <= ifm_row + row_stride;
                        ifm_addr <= ifm_row + row_stride;
                    end else begin
                        rc       <= rc + 16'd1;
                        ifm_addr <= ifm_addr + ADDR_W'(1);
                    end
                end
                DRAIN: d_cnt <= d_cnt + 8'd1;
                FINISH: if (!stall && !last_px) begin
                    if (ofm_x != ow - 8'd1) begin
                        ofm_x    <= ofm_x + 8'd1;
                        pix_base <= pix_base + px_step;
                    end else if (ofm_y != ow - 8'd1) begin
                        ofm_x    <= '0;
                        ofm_y    <= ofm_y + 8'd1;
                        oy_base  <= oy_base + oy_step;
                        pix_base <= oy_base + oy_step;
                    end else begin
                        ofm_x    <= '0;
                        ofm_y    <= '0;
                        tile_idx <= tile_idx + 8'd1;
                        oy_base  <= '0;
                        pix_base <= '0;
                        wgt_base <= wgt_base + ADDR_W'(n_rd);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb_conv_tile_scheduler: table vectors, hand sequences and random layers checked
// against a loop-nest reference model of the read stream and pixel framing.
module tb_conv_tile_scheduler;
    localparam int AW = 20, NPE = 16, RDL = 2;
    logic clk = 1'b0, reset, start, stall;
    logic [3:0] KERNEL_W;
    logic [7:0] IFM_W, IFM_C, OFM_W, OFM_C;
    logic [1:0] stride;
    logic busy, done, cfg_err, ifm_rd_en, wgt_rd_en;
    logic [AW-1:0] ifm_addr, wgt_addr;
    logic [NPE-1:0] PE_reset, PE_finish;
    logic [7:0] ofm_x, ofm_y, tile_idx;

    conv_tile_scheduler #(.ADDR_W(AW), .NUM_PE(NPE), .RD_LAT(RDL)) dut (
        .clk(clk), .reset(reset), .start(start), .KERNEL_W(KERNEL_W), .IFM_W(IFM_W),
        .IFM_C(IFM_C), .OFM_W(OFM_W), .OFM_C(OFM_C), .stride(stride), .stall(stall),
        .busy(busy), .done(done), .cfg_err(cfg_err), .ifm_rd_en(ifm_rd_en),
        .ifm_addr(ifm_addr), .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr),
        .PE_reset(PE_reset), .PE_finish(PE_finish), .ofm_x(ofm_x), .ofm_y(ofm_y),
        .tile_idx(tile_idx));

    always #5 clk = ~clk;

    typedef struct { int c; int ia; int wa; int x; int y; int t; } rd_t;
    typedef struct { int k; int iw; int ic; int ow; int oc; int st; int s; bit err; int lat; int fins; } vec_t;

    int cyc = 0, errors = 0, checks = 0, bad_bits = 0;
    rd_t got_q[$];
    int rst_q[$], fin_q[$], done_q[$];
    vec_t tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifm_rd_en)
            got_q.push_back('{cyc, int'(ifm_addr), int'(wgt_addr), int'(ofm_x), int'(ofm_y), int'(tile_idx)});
        if (PE_reset != '0) rst_q.push_back(cyc);
        if (PE_finish != '0) fin_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if ((PE_reset != '0 && PE_reset != '1) || (PE_finish != '0 && PE_finish != '1) ||
            ifm_rd_en != wgt_rd_en)
            bad_bits++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic outs_nonzero();
        return |{busy, done, cfg_err, ifm_rd_en, wgt_rd_en, ifm_addr, wgt_addr,
                 PE_reset, PE_finish, ofm_x, ofm_y, tile_idx};
    endfunction

    task automatic drive_cfg(input vec_t v);
        KERNEL_W = 4'(v.k); IFM_W = 8'(v.iw); IFM_C = 8'(v.ic);
        OFM_W = 8'(v.ow); OFM_C = 8'(v.oc); stride = 2'(v.st);
    endtask

    task automatic run_layer(input vec_t v, input int extra);
        rd_t e[$];
        int er[$];
        int c0, cw, n, np, p, j, base, lat, budget, s;
        bit err;
        err = v.k == 0 || v.st == 0 || v.ic == 0 || v.ic % 4 != 0 || v.oc == 0 ||
              v.oc % 16 != 0 || v.ow == 0 || (v.ow - 1) * v.st + v.k > v.iw;
        cw = v.ic / 4;
        n = v.k * v.k * cw;
        np = err ? 0 : (v.oc / 16) * v.ow * v.ow;
        s = err ? 0 : v.s;
        p = 0;
        if (!err)
            for (int t = 0; t < v.oc / 16; t++)
                for (int y = 0; y < v.ow; y++)
                    for (int x = 0; x < v.ow; x++) begin
                        base = 2 + p * (n + RDL + 2) + (p > 0 ? s : 0);
                        er.push_back(base);
                        j = 0;
                        for (int ky = 0; ky < v.k; ky++)
                            for (int kx = 0; kx < v.k; kx++)
                                for (int w = 0; w < cw; w++) begin
                                    e.push_back('{base + 1 + j,
                                        ((y * v.st + ky) * v.iw + x * v.st + kx) * cw + w,
                                        t * n + (ky * v.k + kx) * cw + w, x, y, t});
                                    j++;
                                end
                        p++;
                    end
        lat = err ? 2 : 2 + np * (n + RDL + 2) + s;
        got_q.delete(); rst_q.delete(); fin_q.delete();
        bad_bits = 0;
        @(negedge clk);
        drive_cfg(v);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        KERNEL_W = 4'($urandom); IFM_W = 8'($urandom); IFM_C = 8'($urandom);
        OFM_W = 8'($urandom); OFM_C = 8'($urandom); stride = 2'($urandom);
        budget = lat + 20;
        while (!done && budget > 0) begin
            stall = s > 0 && cyc >= c0 + n + 5 && cyc < c0 + n + 5 + s;
            start = extra > 0 && cyc == c0 + extra;
            @(negedge clk);
            budget--;
        end
        stall = 1'b0;
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        chk("latency", cyc - c0, lat);
        chk("cfg_err", cfg_err, err);
        chk("busy_at_done", busy, 1);
        if (v.lat >= 0) begin
            chk("tbl_latency", cyc - c0, v.lat);
            chk("tbl_cfg_err", cfg_err, v.err);
            chk("tbl_finishes", fin_q.size(), v.fins);
        end
        chk("read_count", got_q.size(), e.size());
        for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
            chk($sformatf("rd%0d_ifm_addr", i), got_q[i].ia, e[i].ia);
            chk($sformatf("rd%0d_wgt_addr", i), got_q[i].wa, e[i].wa);
            chk($sformatf("rd%0d_cycle", i), got_q[i].c - c0, e[i].c);
            chk($sformatf("rd%0d_xyt", i), got_q[i].x * 65536 + got_q[i].y * 256 + got_q[i].t,
                e[i].x * 65536 + e[i].y * 256 + e[i].t);
        end
        chk("reset_count", rst_q.size(), er.size());
        for (int i = 0; i < er.size() && i < rst_q.size(); i++)
            chk($sformatf("pe_reset%0d_cycle", i), rst_q[i] - c0, er[i]);
        chk("finish_count", fin_q.size(), np + (np > 0 ? s : 0));
        if (np > 0 && fin_q.size() > 0) begin
            chk("finish_first_cycle", fin_q[0] - c0, 2 + n + RDL + 1);
            chk("finish_last_cycle", fin_q[fin_q.size() - 1] - c0, lat - 1);
        end
        chk("strobe_coherence", bad_bits, 0);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("cfg_err_holds", cfg_err, err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int budget, exp_a[18], mt_i[4], mt_w[4], mt_t[4], s2[4];
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        KERNEL_W = '0; IFM_W = '0; IFM_C = '0; OFM_W = '0; OFM_C = '0; stride = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", outs_nonzero(), 0);
        reset = 1'b0;

        tbl[0] = '{3, 4, 4, 2, 16, 1, 0, 1'b0, 54, 4};
        tbl[1] = '{3, 5, 4, 2, 16, 2, 0, 1'b0, 54, 4};
        tbl[2] = '{1, 1, 8, 1, 32, 1, 0, 1'b0, 14, 2};
        tbl[3] = '{3, 4, 4, 2, 16, 1, 5, 1'b0, 59, 9};
        tbl[4] = '{3, 4, 6, 2, 16, 1, 0, 1'b1, 2, 0};
        tbl[5] = '{3, 4, 4, 3, 16, 1, 0, 1'b1, 2, 0};
        tbl[6] = '{0, 4, 4, 2, 16, 1, 0, 1'b1, 2, 0};
        tbl[7] = '{3, 4, 4, 2, 16, 0, 0, 1'b1, 2, 0};
        tbl[8] = '{3, 4, 4, 2, 24, 1, 0, 1'b1, 2, 0};
        tbl[9] = '{2, 8, 12, 3, 16, 3, 0, 1'b0, 146, 9};
        for (int i = 0; i < 10; i++) run_layer(tbl[i], i == 0 ? 10 : 0);

        exp_a = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 1, 2, 3, 5, 6, 7, 9, 10, 11};
        run_layer(tbl[0], 0);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("basic_ifm%0d", i), got_q[i].ia, exp_a[i]);
            chk($sformatf("basic_wgt%0d", i), got_q[i].wa, i % 9);
        end
        s2 = '{0, 2, 10, 12};
        run_layer(tbl[1], 0);
        for (int i = 0; i < 4; i++) chk($sformatf("stride2_first%0d", i), got_q[i * 9].ia, s2[i]);
        mt_i = '{0, 1, 0, 1}; mt_w = '{0, 1, 2, 3}; mt_t = '{0, 0, 1, 1};
        run_layer(tbl[2], 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mtile_ifm%0d", i), got_q[i].ia, mt_i[i]);
            chk($sformatf("mtile_wgt%0d", i), got_q[i].wa, mt_w[i]);
            chk($sformatf("mtile_tile%0d", i), got_q[i].t, mt_t[i]);
        end

        @(negedge clk);
        drive_cfg(tbl[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 20;
        while (!ifm_rd_en && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("abort_reached_accum", ifm_rd_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_outputs_zero", outs_nonzero(), 0);
        done_q.delete();
        repeat (60) @(negedge clk);
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_idle", busy, 0);
        run_layer(tbl[0], 0);

        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("reset_beats_start", busy, 0);

        for (int r = 0; r < 25; r++) begin
            v.k = $urandom_range(1, 3);
            v.st = $urandom_range(1, 3);
            v.ic = 4 * $urandom_range(1, 3);
            v.oc = 16 * $urandom_range(1, 2);
            v.ow = $urandom_range(1, 3);
            v.iw = (v.ow - 1) * v.st + v.k + $urandom_range(0, 2);
            if ($urandom_range(0, 5) == 0) v.iw = (v.ow - 1) * v.st + v.k - 1;
            if ($urandom_range(0, 7) == 0) v.ic = 6;
            v.s = $urandom_range(0, 1) ? $urandom_range(1, 4) : 0;
            v.err = 1'b0; v.lat = -1; v.fins = 0;
            run_layer(v, $urandom_range(0, 1) ? $urandom_range(3, 12) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_tile_scheduler.md
Name: conv_tile_scheduler

Overview:
Sequencer for the 16-PE convolution datapath. It latches a layer configuration on `start` and walks the loop nest over output tile, output row, output column, kernel row, kernel column and input-channel word. For each step it issues IFM and weight BRAM read addresses. For each output pixel it frames the accumulation with the per-PE `PE_reset` and `PE_finish` strobes. It sits between the control unit and the IFM/weight buffers plus the PE array, and replaces hand-timed `PE_reset`/`PE_finish` pulses.

Parameters:
- ADDR_W, 20, width of the IFM and weight word addresses (one word = 4 channels x 8 bit).
- NUM_PE, 16, PEs per tile; one OFM channel per PE.
- RD_LAT, 2, cycles from the last read issue until that data has been accumulated in the PEs.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a layer.
- KERNEL_W  in  4  kernel width/height K.
- IFM_W  in  8  padded IFM width/height.
- IFM_C  in  8  IFM channels.
- OFM_W  in  8  OFM width/height.
- OFM_C  in  8  OFM channels.
- stride  in  2  convolution stride.
- stall  in  1  output sink not ready; holds the FINISH state.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse at layer end.
- cfg_err  out  1  latched configuration error.
- ifm_rd_en  out  1  IFM read strobe.
- ifm_addr  out  ADDR_W  IFM word address.
- wgt_rd_en  out  1  weight read strobe (same cycle as `ifm_rd_en`).
- wgt_addr  out  ADDR_W  weight word address, same value sent to all PE weight buffers.
- PE_reset  out  NUM_PE  clear accumulators (all bits driven together).
- PE_finish  out  NUM_PE  pixel result valid (all bits driven together).
- ofm_x  out  8  current OFM column.
- ofm_y  out  8  current OFM row.
- tile_idx  out  8  current OFM channel group.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-layer aborts in the next cycle with no `done` pulse.
- Derived values:
  - CW = IFM_C/4.
  - N = K*K*CW (read cycles per pixel).
  - T = OFM_C/NUM_PE (number of tiles).
- IDLE: on `start`, latch every config input (later input changes are ignored), clear `cfg_err`, set `busy`=1, go to CHECK. `start` is ignored while `busy`=1.
- CHECK (1 cycle): error if any of the following holds:
  - K=0;
  - `stride`=0;
  - IFM_C=0 or IFM_C%4≠0;
  - OFM_C=0 or OFM_C%16≠0;
  - OFM_W=0;
  - (OFM_W-1)*stride+K > IFM_W.
- On error: `cfg_err`=1 and go to DONE; no reads are issued. Otherwise go to CLEAR.
- CLEAR (1 cycle): `PE_reset`=all ones, then ACCUM.
- ACCUM (N cycles): `ifm_rd_en`=`wgt_rd_en`=1 every cycle. Loop order: ky outer, kx middle, cw inner.
  - ifm_addr = ((oy*stride+ky)*IFM_W + ox*stride+kx)*CW + cw
  - wgt_addr = tile*N + (ky*K+kx)*CW + cw
  - Compute addresses with incremental adders, no per-cycle multipliers.
  - Arithmetic is unsigned, ADDR_W bits; results are guaranteed to fit for legal configurations.
  - After the last read, go to DRAIN.
- DRAIN (RD_LAT cycles): no strobes, then FINISH.
- FINISH: `PE_finish`=all ones while `stall`=1, and for the one cycle in which `stall`=0. Then advance counters in this order: ox; wrap to oy; wrap to tile. If more pixels remain go to CLEAR, else go to DONE.
- `ofm_x`, `ofm_y`, `tile_idx` hold the pixel being computed from CLEAR through FINISH.
- DONE (1 cycle): `done`=1, `busy`=0 in the following cycle, then IDLE. `cfg_err` holds until the next accepted `start`.
- Timing:
  - Cycles per pixel = N + RD_LAT + 2 (without stall).
  - Layer latency from `start` to `done` = 2 + T*OFM_W²*(N+RD_LAT+2) cycles.
- `start` together with `reset` in the same cycle: `reset` wins.

Test Plan:
- Basic pixel: K=3, IFM_C=4, IFM_W=4, OFM_W=2, OFM_C=16, stride=1, RD_LAT=2.
  - Pixel (0,0) `ifm_addr` = 0,1,2,4,5,6,8,9,10.
  - Pixel (0,1) `ifm_addr` = 1,2,3,5,6,7,9,10,11.
  - `wgt_addr` = 0..8 for every pixel.
  - `PE_reset` precedes each 9-read burst; `PE_finish` comes 3 cycles after the last read.
  - 4 `PE_finish` pulses; `done` 54 cycles after `start`.
- Stride 2: IFM_W=5, OFM_W=2, K=3, IFM_C=4 -> first `ifm_addr` per pixel = 0, 2, 10, 12.
- Multi-tile and multi-word: IFM_C=8, OFM_C=32, K=1, IFM_W=OFM_W=1.
  - Tile 0: `wgt_addr` 0,1 and `ifm_addr` 0,1.
  - Tile 1: `wgt_addr` 2,3 and `ifm_addr` 0,1.
  - `tile_idx` 0 then 1; 2 `PE_finish` pulses.
- Stall: hold `stall`=1 for 5 cycles during the first FINISH -> `PE_finish` high 6 cycles, no reads issued meanwhile, address sequence unchanged afterwards, `done` delayed by exactly 5 cycles.
- Config error: IFM_C=6 (and separately OFM_W=3, K=3, IFM_W=4) -> `cfg_err`=1, `done` 2 cycles after `start`, `ifm_rd_en` never asserted, `PE_reset` never asserted.
- Abort and restart:
  - Assert `reset` during ACCUM -> next cycle all outputs 0, no `done` pulse.
  - A new `start` then runs the basic-pixel case correctly.
  - A second `start` pulse while `busy` is ignored.
